// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: predicts each next value of a loadable XNOR LFSR counter, flags mismatches, lock-up and period.
// Define LFSR_CHK_SNAP_EN to add snap_exp/snap_obs capture of the first mismatch after rst/clr.
module lfsr_seq_checker #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter int               ECW   = 16,
    parameter int               PW    = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_n,
    input  logic             cen,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] count,
    input  logic             clr,
    output logic             in_sync,
    output logic             err,
    output logic [ECW-1:0]   err_cnt,
    output logic             locked,
    output logic [PW-1:0]    period,
    output logic             period_vld
`ifdef LFSR_CHK_SNAP_EN
    ,
    output logic [WIDTH-1:0] snap_exp,
    output logic [WIDTH-1:0] snap_obs
`endif
);
    typedef enum logic {UNSYNC = 1'b0, SYNC = 1'b1} state_t;
    localparam logic [WIDTH-1:0] ONES = '1;
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ~^(x & TAPS)};
    endfunction
    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, ref_q, ref_d;
    logic [PW-1:0]    step_cnt_q, step_cnt_d, period_q, period_d;
    logic [ECW-1:0]   err_cnt_q, err_cnt_d;
    logic             err_q, err_d, locked_q, locked_d, period_vld_q, period_vld_d;
    logic [WIDTH-1:0] nxt;
    logic             sync, adv, mism, hit;
    assign nxt  = step(count);
    assign sync = state_q == SYNC;
    assign adv  = load_n && cen;
    assign mism = sync && count != exp_q;
    assign hit  = sync && adv && nxt == ref_q;
    // Prediction always follows the observed count, so one bad value costs exactly one err.
    always_comb begin
        exp_d        = !load_n ? data : cen ? nxt : count;
        state_d      = !load_n ? SYNC : state_q;
        ref_d        = !load_n ? data : ref_q;
        step_cnt_d   = !load_n ? '0 : (sync && adv) ? (hit ? '0 : step_cnt_q + PW'(1)) : step_cnt_q;
        err_d        = mism;
        err_cnt_d    = clr ? '0 : (mism && ~&err_cnt_q) ? err_cnt_q + ECW'(1) : err_cnt_q;
        locked_d     = (clr || (!load_n && data != ONES)) ? 1'b0 : (sync && count == ONES) ? 1'b1 : locked_q;
        period_d     = clr ? '0 : hit ? step_cnt_q + PW'(1) : period_q;
        period_vld_d = hit && !clr;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= UNSYNC;
            exp_q        <= '0;
            ref_q        <= '0;
            step_cnt_q   <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            locked_q     <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            ref_q        <= ref_d;
            step_cnt_q   <= step_cnt_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
            locked_q     <= locked_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end
    assign in_sync    = state_q == SYNC;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign locked     = locked_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;
`ifdef LFSR_CHK_SNAP_EN
    logic             snap_taken_q, snap_taken_d;
    logic [WIDTH-1:0] snap_exp_q, snap_exp_d, snap_obs_q, snap_obs_d;
    always_comb begin
        snap_taken_d = !clr && (snap_taken_q || mism);
        snap_exp_d   = clr ? '0 : (mism && !snap_taken_q) ? exp_q : snap_exp_q;
        snap_obs_d   = clr ? '0 : (mism && !snap_taken_q) ? count : snap_obs_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_taken_q <= 1'b0;
            snap_exp_q   <= '0;
            snap_obs_q   <= '0;
        end else begin
            snap_taken_q <= snap_taken_d;
            snap_exp_q   <= snap_exp_d;
            snap_obs_q   <= snap_obs_d;
        end
    end
    assign snap_exp = snap_exp_q;
    assign snap_obs = snap_obs_q;
`endif
endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Passive monitor placed directly downstream of the loadable LFSR counter (count_load).
- It taps the counter's control inputs (load_n, cen, data) and its count output, predicts every next count value, and flags mismatches.
- It also reports lock-up in the forbidden state and measures the sequence period.
- Used in simulation benches and as an on-chip self-check next to the counter.

Parameters:
- WIDTH, 8, counter width in bits; must match the monitored counter.
- TAPS, 8'hB8, feedback tap mask; bit i set means count[i] feeds the XNOR.
- ECW, 16, width of the error counter.
- PW, WIDTH+1, width of the period measurement.

Ports:
- clk  in  1  clock, shared with the counter
- rst  in  1  asynchronous reset, active-high
- load_n  in  1  counter load, active-low (tapped)
- cen  in  1  counter enable (tapped)
- data  in  WIDTH  counter load value (tapped)
- count  in  WIDTH  counter output (tapped)
- clr  in  1  synchronous clear of err_cnt, locked and period
- in_sync  out  1  checker has a valid prediction
- err  out  1  one-cycle mismatch pulse
- err_cnt  out  ECW  saturating mismatch count
- locked  out  1  counter observed in the all-ones lock-up state
- period  out  PW  steps between consecutive returns to the reference value
- period_vld  out  1  one-cycle pulse when period updates

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM goes to UNSYNC; exp, ref and step_cnt are 0.
- Step function: fb = XNOR-reduce(count & TAPS); step(x) = {x[WIDTH-2:0], fb}. All-ones maps to itself (lock-up state).
- Counter contract being checked:
  - load_n=0 loads data regardless of cen (load has priority).
  - Otherwise cen=1 gives count <= step(count).
  - Otherwise count holds.
- Prediction: at every clk edge the checker registers:
  - exp <= data if load_n=0.
  - Otherwise exp <= step(count) if cen=1.
  - Otherwise exp <= count.
- FSM states UNSYNC, SYNC:
  - UNSYNC: no comparisons. A sampled load_n=0 moves to SYNC at that edge and captures ref <= data, step_cnt <= 0.
  - SYNC: at each edge, compare count against the exp registered at the previous edge.
- Mismatch in SYNC: err=1 for exactly one cycle, starting the cycle after the wrong count is presented. err_cnt increments, saturating at all-ones.
- Resynchronisation: the next prediction uses the observed count, so a single fault produces exactly one err.
- in_sync = (state==SYNC). It stays in SYNC across mismatches; only rst returns the FSM to UNSYNC.
- Period measurement in SYNC:
  - step_cnt increments on each cen step (load_n=1, cen=1).
  - When the stepped-to value equals ref: period <= step_cnt+1, period_vld pulses, step_cnt <= 0.
  - A load re-captures ref and zeroes step_cnt; period holds its last value.
- Expected periods: WIDTH=8 with default TAPS, seed not 8'hFF gives 255. Seed 8'hFF gives 1.
- locked: set when a compared count equals all-ones. Cleared by clr, rst, or a load of non-all-ones data.
- Simultaneous events:
  - clr in the same cycle as a mismatch: the clear wins, err_cnt=0, err still pulses.
  - load_n=0 and cen=1 together: the prediction is data.
- Latency: err, locked and period_vld are all registered, one cycle after the observed count.

Optional Feature:
- Macro: LFSR_CHK_SNAP_EN.
- Defined: adds outputs snap_exp[WIDTH] and snap_obs[WIDTH]. They capture the expected and observed values of the first mismatch after rst/clr and hold until the next rst/clr.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 with random inputs -> all outputs 0, in_sync=0; no err while UNSYNC even when count is garbage.
- Load 8'h01, then cen=1 for 600 cycles -> count sequence 01,03,07,...; err never asserts; period_vld pulses every 255 steps with period=255.
- Inject a fault: after load 8'h01 and one step, drive count=8'h00 where 8'h03 is expected -> single err pulse, err_cnt=1. With LFSR_CHK_SNAP_EN: snap_exp=8'h03, snap_obs=8'h00. Subsequent correct steps from 8'h00 give no further err.
- Load 8'hFF with cen=1 -> locked=1 one cycle after the first compare, period=1 pulsing every step. Then load 8'h5A -> locked=0.
- cen=0 for 10 cycles -> count holds, no err. Change count while cen=0 -> err pulse.
- With ECW=4, inject 20 faults -> err_cnt=15 (saturated). Assert clr in the same cycle as the 21st fault -> err_cnt=0, err=1.
